dmem_responder: RTL and testbench

Memory-side responder for the core's data-memory port. Accepts one load or store request at a time over a valid/ready handshake, services it from an internal word-organised array after a fixed configurable latency, and returns read data or a write acknowledgement over a second valid/ready handshake. It replaces the single-cycle data memory behind the pipeline's MEM stage with a realistic multi-cycle target, and handles byte/half/word lane selection, range checking and alignment checking.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_byte_lanes.sv | 49 ++++
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder.
// Size codes, FSM states and the default array base address.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h0100_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_byte_lanes.sv
// Byte-lane steering for the data-memory responder.
// Merges store data into the old word and right-aligns load data.
import dmem_pkg::*;

module dmem_byte_lanes (
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    logic [4:0]  shamt;
    logic [31:0] mask;
    logic [31:0] shifted_old;
    logic [31:0] shifted_wdata;

    assign shamt         = {offset, 3'b000};
    assign shifted_old   = old_word >> shamt;
    assign shifted_wdata = wdata << shamt;

    // Lane mask and load extraction selected by access size
    always_comb begin
        mask      = 32'h0;
        load_data = 32'h0;
        case (size)
            SIZE_BYTE: begin
                mask      = 32'h0000_00FF << shamt;
                load_data = {24'h0, shifted_old[7:0]};
            end
            SIZE_HALF: begin
                mask      = 32'h0000_FFFF << shamt;
                load_data = {16'h0, shifted_old[15:0]};
            end
            SIZE_WORD: begin
                mask      = 32'hFFFF_FFFF;
                load_data = old_word;
            end
            default: begin
                mask      = 32'h0;
                load_data = 32'h0;
            end
        endcase
    end

    assign merged = (old_word & ~mask) | (shifted_wdata & mask);

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with valid/ready request and response.
// Define DMEM_MISALIGN_CHECK_EN to fault misaligned half/word accesses.
import dmem_pkg::*;

module dmem_responder #(
    parameter int          DEPTH_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int          LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    dmem_state_t state;
    logic [3:0]  count;
    logic        write_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        acc_write;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [31:0] eff_addr;
    logic [31:0] offset;
    logic [AW-1:0] word_idx;
    logic        misaligned;
    logic        out_of_range;
    logic        bad_size;
    logic        fault;
    logic        go_resp;
    logic [31:0] old_word;
    logic [31:0] merged;
    logic [31:0] load_data;
    logic [31:0] resp_data;

    assign req_ready = (state == IDLE) && !reset;

    // With single-cycle latency the access uses the live request fields
    assign acc_write = (state == IDLE) ? req_write : write_q;
    assign acc_size  = (state == IDLE) ? req_size  : size_q;
    assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;

`ifdef DMEM_MISALIGN_CHECK_EN
    // Misaligned half/word accesses fault; address used as given
    always_comb begin
        eff_addr   = acc_addr;
        misaligned = 1'b0;
        if (acc_size == SIZE_HALF && acc_addr[0])
            misaligned = 1'b1;
        if (acc_size == SIZE_WORD && acc_addr[1:0] != 2'b00)
            misaligned = 1'b1;
    end
`else
    // Low address bits forced to the natural alignment of the size
    always_comb begin
        eff_addr   = acc_addr;
        misaligned = 1'b0;
        if (acc_size == SIZE_HALF)
            eff_addr[0] = 1'b0;
        if (acc_size == SIZE_WORD)
            eff_addr[1:0] = 2'b00;
    end
`endif

    assign offset       = eff_addr - BASE_ADDR;
    assign word_idx     = offset[AW+1:2];
    assign bad_size     = (acc_size == 2'd3);
    assign out_of_range = (eff_addr < BASE_ADDR) ||
                          ({2'b00, offset[31:2]} >= 32'(DEPTH_WORDS));
    assign fault        = bad_size || out_of_range || misaligned;

    assign go_resp = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
                     ((state == WAIT) && (count == 4'd0));

    assign old_word = mem[word_idx];

    dmem_byte_lanes u_lanes (
        .size      (acc_size),
        .offset    (eff_addr[1:0]),
        .old_word  (old_word),
        .wdata     (acc_wdata),
        .merged    (merged),
        .load_data (load_data)
    );

    assign resp_data = (fault || acc_write) ? 32'h0 : load_data;

    // Store commits on the edge that enters RESP; contents never reset
    always_ff @(posedge clock) begin
        if (!reset && go_resp && acc_write && !fault)
            mem[word_idx] <= merged;
    end

    // Request/response FSM with latency counter and registered response
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            write_q   <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_error <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        write_q <= req_write;
                        size_q  <= req_size;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        count   <= CNT_INIT;
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= resp_data;
                            rsp_error <= fault;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= resp_data;
                        rsp_error <= fault;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_error <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (LATENCY=2, default depth/base).
// Misalignment expectations follow DMEM_MISALIGN_CHECK_EN.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    int   n_total = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    logic prev_valid = 1'b0;
    exp_t exp_q[$];

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam logic        MIS_ERR  = 1'b1;
    localparam logic [31:0] MIS_WORD = 32'h5566_7788;
`else
    localparam logic        MIS_ERR  = 1'b0;
    localparam logic [31:0] MIS_WORD = 32'h1234_5678;
`endif

    dmem_responder dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     name, act, exp, cyc);
    endtask

    // Monitor: latency on rising valid, data/error on each handshake
    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (rsp_valid && !prev_valid)
                check("latency", 32'(cyc - acc_cyc), 32'd2);
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_rdata", rsp_rdata, e.data);
                    check("rsp_error", {31'h0, rsp_error}, {31'h0, e.err});
                end
            end
            prev_valid = rsp_valid;
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok = 1'b0;
        @(posedge clock);
        #1;
        req_valid = 1'b1;
        req_write = w;
        req_size  = sz;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("req_timeout", 32'd1, 32'd0);
        acc_cyc = cyc + 1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic req(input logic w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] ed, input logic ee);
        exp_t e;
        e.data = ed;
        e.err  = ee;
        exp_q.push_back(e);
        issue(w, sz, a, d);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_req_ready", {31'h0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_error", {31'h0, rsp_error}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ready", {31'h0, req_ready}, 32'd1);

        // Word store/load and byte/half lanes
        req(1, 2'd2, 32'h0100_0010, 32'hDEAD_BEEF, 32'h0, 0);
        req(0, 2'd2, 32'h0100_0010, 32'h0, 32'hDEAD_BEEF, 0);
        req(1, 2'd0, 32'h0100_0013, 32'h0000_00AA, 32'h0, 0);
        req(0, 2'd2, 32'h0100_0010, 32'h0, 32'hAAAD_BEEF, 0);
        req(0, 2'd1, 32'h0100_0012, 32'h0, 32'h0000_AAAD, 0);
        req(0, 2'd1, 32'h0100_0010, 32'h0, 32'h0000_BEEF, 0);
        req(0, 2'd0, 32'h0100_0011, 32'h0, 32'h0000_00BE, 0);

        // Boundary words and faults
        req(1, 2'd2, 32'h0100_0000, 32'h0BAD_F00D, 32'h0, 0);
        req(1, 2'd2, 32'h0100_FFFC, 32'hCAFE_F00D, 32'h0, 0);
        req(0, 2'd2, 32'h00FF_FFFC, 32'h0, 32'h0, 1);
        req(0, 2'd3, 32'h0100_0010, 32'h0, 32'h0, 1);
        req(1, 2'd3, 32'h0100_0010, 32'h1111_1111, 32'h0, 1);
        req(1, 2'd2, 32'h0101_0000, 32'h2222_2222, 32'h0, 1);
        req(0, 2'd2, 32'h0100_0010, 32'h0, 32'hAAAD_BEEF, 0);
        req(0, 2'd2, 32'h0100_0000, 32'h0, 32'h0BAD_F00D, 0);
        req(0, 2'd2, 32'h0100_FFFC, 32'h0, 32'hCAFE_F00D, 0);

        // Misaligned word store
        req(1, 2'd2, 32'h0100_0020, 32'h5566_7788, 32'h0, 0);
        req(1, 2'd2, 32'h0100_0022, 32'h1234_5678, 32'h0, MIS_ERR);
        req(0, 2'd2, 32'h0100_0020, 32'h0, MIS_WORD, 0);
        drain();

        // Backpressure with a second request pending
        rsp_ready = 1'b0;
        req(0, 2'd2, 32'h0100_0020, 32'h0, MIS_WORD, 0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (rsp_valid) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clock);
            end
            if (!seen) check("bp_rsp_timeout", 32'd1, 32'd0);
        end
        @(posedge clock);
        #1;
        begin
            exp_t e;
            e.data = 32'hAAAD_BEEF;
            e.err  = 1'b0;
            exp_q.push_back(e);
        end
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h0100_0010;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp_valid", {31'h0, rsp_valid}, 32'd1);
            check("bp_rdata", rsp_rdata, MIS_WORD);
            check("bp_req_ready", {31'h0, req_ready}, 32'd0);
            if (i < 4) @(posedge clock);
        end
        @(posedge clock);
        #1;
        rsp_ready = 1'b1;
        @(negedge clock);
        check("hs_req_ready", {31'h0, req_ready}, 32'd0);
        @(negedge clock);
        check("after_hs_ready", {31'h0, req_ready}, 32'd1);
        check("after_hs_valid", {31'h0, rsp_valid}, 32'd0);
        acc_cyc = cyc + 1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        drain();

        // Reset while a store waits: no array update
        issue(1, 2'd2, 32'h0100_0010, 32'h0000_0000);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        check("abort_req_ready", {31'h0, req_ready}, 32'd1);
        req(0, 2'd2, 32'h0100_0010, 32'h0, 32'hAAAD_BEEF, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
